autocorr_engine: RTL and testbench
==================================

AUTOCORR_ENGINE -- requirements
Module: autocorr_engine

Interface
REQ-001 Parameter N_SAMPLES, default 480, frame length in samples.
REQ-002 Parameter LAG_MIN, default 47, first lag emitted.
REQ-003 Parameter LAG_MAX, default 141, last lag emitted.
REQ-004 Parameter SAMPLE_W, default 16, signed sample width.
REQ-005 Clk  input  1  sole clock; all state updates on posedge Clk.
REQ-006 Reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin a new frame capture; sampled only in IDLE.
REQ-008 sample_in  input  SAMPLE_W  signed audio sample.
REQ-009 sample_valid  input  1  sample_in qualifier; sampled only in CAPTURE.
REQ-010 busy  output  1  high in CAPTURE and COMPUTE.
REQ-011 r_lag  output  10  lag index of the current r_val.
REQ-012 r_val  output  72  signed autocorrelation value, sign-extended.
REQ-013 r_valid  output  1  one-cycle strobe qualifying r_lag/r_val.
REQ-014 done  output  1  one-cycle pulse after the final lag is emitted.
REQ-015 acf_ready  output  1  level; high from done until next accepted start; drives the downstream peak-search enable.

Function
REQ-016 The FSM SHALL have states IDLE, CAPTURE, COMPUTE, EMIT, DONE.
REQ-017 IDLE with start=1 SHALL go to CAPTURE, clear write index and acf_ready.
REQ-018 In CAPTURE each cycle with sample_valid=1 SHALL store sample_in at buffer[wr_idx] and increment wr_idx; sample_valid=0 cycles hold.
REQ-019 After the N_SAMPLES-th stored sample, the next state SHALL be COMPUTE with lag=LAG_MIN, n=0, acc=0.
REQ-020 COMPUTE SHALL perform exactly one MAC per cycle: acc += buffer[n]*buffer[n+lag] (full signed 2*SAMPLE_W product), for n = 0..N_SAMPLES-1-lag, i.e. N_SAMPLES-lag cycles per lag.
REQ-021 The cycle after the last MAC of a lag SHALL be EMIT: r_valid=1, r_lag=lag, r_val=acc sign-extended to 72 bits; then acc and n clear.
REQ-022 From EMIT, lag<LAG_MAX SHALL return to COMPUTE with lag+1; lag=LAG_MAX SHALL go to DONE.
REQ-023 DONE SHALL last one cycle with done=1, set acf_ready=1, then go to IDLE.
REQ-024 Accumulator SHALL be at least 2*SAMPLE_W+ceil(log2(N_SAMPLES)) bits (41 at defaults); no overflow or saturation occurs.
REQ-025 Compute latency from first COMPUTE cycle to done SHALL be sum over lags of (N_SAMPLES-lag+1) plus 1 cycle (36766 at defaults).
REQ-026 start while busy or in DONE SHALL be ignored; sample_valid outside CAPTURE SHALL be ignored.
REQ-027 r_valid and done SHALL never be high together; r_lag/r_val hold last emitted values while r_valid=0.

Reset
REQ-028 Reset=1 at a clock edge SHALL force IDLE and zero busy, r_lag, r_val, r_valid, done, acf_ready, acc, wr_idx, lag, n, from any state including mid-CAPTURE/COMPUTE.
REQ-029 Buffer contents SHALL not be cleared by reset and SHALL not affect results of the next frame.

Configuration
REQ-030 Macro ACF_LAG0_EN defined: COMPUTE SHALL first compute lag 0 (N_SAMPLES MACs) and emit it with r_lag=0 before LAG_MIN; latency grows by N_SAMPLES+1 cycles.
REQ-031 ACF_LAG0_EN undefined: lag 0 SHALL not be computed or emitted; first emit is r_lag=LAG_MIN.

Verification
REQ-032 All 480 samples = 1 -> 95 strobes; r_val(47)=433, r_val(141)=339; done exactly 36766 cycles after COMPUTE entry.
REQ-033 x[0]=100, x[100]=100, others 0 -> r_val(100)=10000, every other lag 0.
REQ-034 All samples = -32768 -> r_val(47)=464930209792 (positive), upper 72-bit sign bits all 0.
REQ-035 Reset asserted mid-COMPUTE at lag 80 -> next cycle busy=0, r_valid=0, acf_ready=0; following start and frame produce correct full results.
REQ-036 start pulsed during COMPUTE and sample_valid in IDLE -> no effect; emitted values match undisturbed run.
REQ-037 ACF_LAG0_EN defined, all samples = 1 -> first strobe r_lag=0, r_val=480, followed by lags 47..141 as REQ-032.

Source files
------------

// File: rtl/autocorr_engine.sv
// autocorr_engine: captures a frame of signed samples, then emits r[lag] for LAG_MIN..LAG_MAX, one MAC per cycle.
// Optional macro ACF_LAG0_EN: lag 0 (frame energy) is computed and emitted ahead of LAG_MIN.
module autocorr_engine #(
  parameter int N_SAMPLES = 480,
  parameter int LAG_MIN   = 47,
  parameter int LAG_MAX   = 141,
  parameter int SAMPLE_W  = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [SAMPLE_W-1:0] sample_in_i,
  input  logic                sample_valid_i,
  output logic                busy_o,
  output logic [9:0]          r_lag_o,
  output logic [71:0]         r_val_o,
  output logic                r_valid_o,
  output logic                done_o,
  output logic                acf_ready_o
);

  // state     | meaning
  // S_IDLE    | waiting for start
  // S_CAPTURE | storing qualified samples into the frame buffer
  // S_COMPUTE | one MAC per cycle for the current lag
  // S_EMIT    | r_valid strobe for the finished lag, clear acc/n
  // S_DONE    | one-cycle done pulse, acf_ready raised
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_EMIT    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam int IDX_W  = $clog2(N_SAMPLES);
  localparam int PROD_W = 2 * SAMPLE_W;
  localparam int ACC_W  = PROD_W + $clog2(N_SAMPLES);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SAMPLES - 1);
  localparam logic [IDX_W-1:0] LAG_MIN_I = IDX_W'(LAG_MIN);
  localparam logic [IDX_W-1:0] LAG_MAX_I = IDX_W'(LAG_MAX);
`ifdef ACF_LAG0_EN
  localparam logic [IDX_W-1:0] FIRST_LAG = '0;
`else
  localparam logic [IDX_W-1:0] FIRST_LAG = LAG_MIN_I;
`endif

  logic [2:0]              state_q, state_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]        n_q, n_d;
  logic [IDX_W-1:0]        lag_q, lag_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [9:0]              r_lag_q, r_lag_d;
  logic [71:0]             r_val_q, r_val_d;
  logic                    acf_ready_q, acf_ready_d;

  logic signed [SAMPLE_W-1:0] buf_mem [N_SAMPLES];
  logic signed [SAMPLE_W-1:0] tap_a, tap_b;
  logic signed [PROD_W-1:0]   prod;
  logic [IDX_W-1:0]           last_n;
  logic                       buf_we;

  assign buf_we = (state_q == S_CAPTURE) && sample_valid_i && !reset_i;
  assign tap_a  = buf_mem[n_q];
  assign tap_b  = buf_mem[n_q + lag_q];
  assign prod   = PROD_W'(tap_a) * PROD_W'(tap_b);
  assign last_n = LAST_IDX - lag_q;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    n_d         = n_q;
    lag_d       = lag_q;
    acc_d       = acc_q;
    r_lag_d     = r_lag_q;
    r_val_d     = r_val_q;
    acf_ready_d = acf_ready_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d     = S_CAPTURE;
          wr_idx_d    = '0;
          acf_ready_d = 1'b0;
        end
      end
      S_CAPTURE: begin
        if (sample_valid_i) begin
          wr_idx_d = wr_idx_q + IDX_W'(1);
          if (wr_idx_q == LAST_IDX) begin
            state_d = S_COMPUTE;
            lag_d   = FIRST_LAG;
            n_d     = '0;
            acc_d   = '0;
          end
        end
      end
      S_COMPUTE: begin
        acc_d = acc_q + ACC_W'(prod);
        if (n_q == last_n) begin
          // result registers load with the final sum so they are valid during EMIT
          state_d = S_EMIT;
          r_lag_d = 10'(lag_q);
          r_val_d = 72'(acc_d);
        end else begin
          n_d = n_q + IDX_W'(1);
        end
      end
      S_EMIT: begin
        acc_d = '0;
        n_d   = '0;
        if (lag_q == LAG_MAX_I) begin
          state_d     = S_DONE;
          acf_ready_d = 1'b1;
        end else begin
          state_d = S_COMPUTE;
          lag_d   = (lag_q < LAG_MIN_I) ? LAG_MIN_I : lag_q + IDX_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      wr_idx_q    <= '0;
      n_q         <= '0;
      lag_q       <= '0;
      acc_q       <= '0;
      r_lag_q     <= '0;
      r_val_q     <= '0;
      acf_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      n_q         <= n_d;
      lag_q       <= lag_d;
      acc_q       <= acc_d;
      r_lag_q     <= r_lag_d;
      r_val_q     <= r_val_d;
      acf_ready_q <= acf_ready_d;
    end
  end

  // frame buffer is deliberately not reset; every frame overwrites all entries
  always_ff @(posedge clk_i) begin
    if (buf_we) buf_mem[wr_idx_q] <= sample_in_i;
  end

  assign busy_o      = (state_q == S_CAPTURE) || (state_q == S_COMPUTE) || (state_q == S_EMIT);
  assign r_valid_o   = (state_q == S_EMIT);
  assign done_o      = (state_q == S_DONE);
  assign r_lag_o     = r_lag_q;
  assign r_val_o     = r_val_q;
  assign acf_ready_o = acf_ready_q;

endmodule

// File: tb/tb_autocorr_engine.sv
// tb_autocorr_engine: scoreboard bench, default-size instance plus a short-frame instance run in parallel.
// Honours ACF_LAG0_EN when the design is built with it.
module tb_autocorr_engine;
  localparam int N0   = 480;
  localparam int N1   = 160;
  localparam int LMIN = 47;
  localparam int LMAX = 141;
`ifdef ACF_LAG0_EN
  localparam int NLAGS = LMAX - LMIN + 2;
`else
  localparam int NLAGS = LMAX - LMIN + 1;
`endif

  typedef struct { int lag; longint val; } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic rst0 = 1'b1, start0, sv0, busy0, rvalid0, done0, rdy0;
  logic [15:0] sin0;
  logic [9:0]  rlag0;
  logic [71:0] rval0;
  logic rst1 = 1'b1, start1, sv1, busy1, rvalid1, done1, rdy1;
  logic [15:0] sin1;
  logic [9:0]  rlag1;
  logic [71:0] rval1;

  autocorr_engine u_dut0 (
    .clk_i(clk), .reset_i(rst0), .start_i(start0), .sample_in_i(sin0), .sample_valid_i(sv0),
    .busy_o(busy0), .r_lag_o(rlag0), .r_val_o(rval0), .r_valid_o(rvalid0), .done_o(done0),
    .acf_ready_o(rdy0));

  autocorr_engine #(.N_SAMPLES(N1), .LAG_MIN(LMIN), .LAG_MAX(LMAX), .SAMPLE_W(16)) u_dut1 (
    .clk_i(clk), .reset_i(rst1), .start_i(start1), .sample_in_i(sin1), .sample_valid_i(sv1),
    .busy_o(busy1), .r_lag_o(rlag1), .r_val_o(rval1), .r_valid_o(rvalid1), .done_o(done1),
    .acf_ready_o(rdy1));

  int x0 [N0];
  int x1 [N1];
  exp_t sbq0 [$];
  exp_t sbq1 [$];
  logic [71:0] got0 [256];
  logic [71:0] got1 [256];
  int nstr0 = 0, nstr1 = 0;
  logic [9:0]  hold_lag0 = '0, hold_lag1 = '0;
  logic [71:0] hold_val0 = '0, hold_val1 = '0;
  int passed = 0, total = 0;

  function automatic void chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endfunction

  // reference: r[lag] = sum over n of x[n]*x[n+lag], straight from the definition
  function automatic longint ref_acf(input int i, input int lag);
    longint s = 0;
    int n = (i == 0) ? N0 : N1;
    for (int k = 0; k + lag < n; k++) begin
      if (i == 0) s += longint'(x0[k]) * longint'(x0[k+lag]);
      else        s += longint'(x1[k]) * longint'(x1[k+lag]);
    end
    return s;
  endfunction

  function automatic longint exp_latency(input int n);
    longint s = 1;
`ifdef ACF_LAG0_EN
    s += longint'(n + 1);
`endif
    for (int l = LMIN; l <= LMAX; l++) s += longint'(n - l + 1);
    return s;
  endfunction

  function automatic void push_exp(input int i);
    exp_t e;
`ifdef ACF_LAG0_EN
    e.lag = 0; e.val = ref_acf(i, 0);
    if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
`endif
    for (int l = LMIN; l <= LMAX; l++) begin
      e.lag = l; e.val = ref_acf(i, l);
      if (i == 0) sbq0.push_back(e); else sbq1.push_back(e);
    end
  endfunction

  task automatic mon_one(input int i, input logic v, input logic [9:0] lag, input logic [71:0] val,
                         input logic d, input logic rdy);
    exp_t e;
    int qs;
    logic hold_ok;
    qs = (i == 0) ? sbq0.size() : sbq1.size();
    hold_ok = (i == 0) ? (lag == hold_lag0 && val == hold_val0) : (lag == hold_lag1 && val == hold_val1);
    if (v) begin
      chk(i == 0 ? "u0_valid_with_done" : "u1_valid_with_done", longint'(d), longint'(0));
      if (qs == 0) begin
        total++;
        $display("FAIL u%0d_unexpected_strobe: got lag %0d, expected no strobe", i, lag);
      end else begin
        if (i == 0) e = sbq0.pop_front(); else e = sbq1.pop_front();
        chk($sformatf("u%0d_r_lag", i), longint'(lag), longint'(e.lag));
        chk($sformatf("u%0d_r_val_lag%0d", i, e.lag), longint'($signed(val[63:0])), e.val);
        chk($sformatf("u%0d_sext_lag%0d", i, e.lag), longint'(val[71:64] == {8{val[63]}}), longint'(1));
      end
      if (i == 0) begin hold_lag0 = lag; hold_val0 = val; got0[lag[7:0]] = val; nstr0++; end
      else        begin hold_lag1 = lag; hold_val1 = val; got1[lag[7:0]] = val; nstr1++; end
    end else begin
      chk(i == 0 ? "u0_hold" : "u1_hold", longint'(hold_ok), longint'(1));
    end
    if (d) chk(i == 0 ? "u0_ready_at_done" : "u1_ready_at_done", longint'(rdy), longint'(1));
  endtask

  always @(negedge clk) begin
    if (!rst0) mon_one(0, rvalid0, rlag0, rval0, done0, rdy0);
    if (!rst1) mon_one(1, rvalid1, rlag1, rval1, done1, rdy1);
  end

  task automatic drive(input int i, input logic st, input logic v, input logic [15:0] s);
    if (i == 0) begin start0 = st; sv0 = v; sin0 = s; end
    else        begin start1 = st; sv1 = v; sin1 = s; end
  endtask

  task automatic reset_chk(input int i);
    logic b, rv, d, r;
    logic [9:0] l;
    logic [71:0] v;
    b = (i == 0) ? busy0 : busy1;   rv = (i == 0) ? rvalid0 : rvalid1;
    d = (i == 0) ? done0 : done1;   r  = (i == 0) ? rdy0 : rdy1;
    l = (i == 0) ? rlag0 : rlag1;   v  = (i == 0) ? rval0 : rval1;
    chk($sformatf("u%0d_rst_busy", i), longint'(b), longint'(0));
    chk($sformatf("u%0d_rst_r_valid", i), longint'(rv), longint'(0));
    chk($sformatf("u%0d_rst_done", i), longint'(d), longint'(0));
    chk($sformatf("u%0d_rst_acf_ready", i), longint'(r), longint'(0));
    chk($sformatf("u%0d_rst_r_lag", i), longint'(l), longint'(0));
    chk($sformatf("u%0d_rst_r_val_zero", i), longint'(v == '0), longint'(1));
  endtask

  task automatic send_frame(input int i, input int gap_pct, output longint entry);
    int n = (i == 0) ? N0 : N1;
    int smp;
    push_exp(i);
    drive(i, 1'b1, 1'b0, 16'h0);
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) begin
      while (int'($urandom_range(0, 99)) < gap_pct) begin
        drive(i, 1'b0, 1'b0, 16'($urandom));
        @(posedge clk); #1;
      end
      smp = (i == 0) ? x0[k] : x1[k];
      drive(i, 1'b0, 1'b1, 16'(smp));
      @(posedge clk); #1;
    end
    drive(i, 1'b0, 1'b0, 16'h0);
    entry = cyc;
  endtask

  task automatic wait_done(input int i, input bit disturb, input longint entry, input string name);
    bit seen = 1'b0;
    longint lat_exp = exp_latency((i == 0) ? N0 : N1);
    for (int c = 0; c < 60000 && !seen; c++) begin
      @(negedge clk);
      if (((i == 0) ? done0 : done1) === 1'b1) begin
        seen = 1'b1;
        drive(i, 1'b0, 1'b0, 16'h0);
        chk({name, "_latency"}, cyc - entry + 1, lat_exp);
      end else if (disturb) begin
        drive(i, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 16'($urandom));
      end
    end
    if (!seen) begin
      total++;
      $display("FAIL %s_timeout: got no done, expected done within 60000 cycles", name);
    end
    @(posedge clk); #1;
    chk({name, "_ready_after"}, longint'((i == 0) ? rdy0 : rdy1), longint'(1));
    chk({name, "_busy_after"}, longint'((i == 0) ? busy0 : busy1), longint'(0));
    chk({name, "_queue_empty"}, longint'((i == 0) ? sbq0.size() : sbq1.size()), longint'(0));
  endtask

  initial begin
    drive(0, 1'b0, 1'b0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;
    reset_chk(0);
    reset_chk(1);
    fork
      begin : inst0
        longint ent;
        foreach (x0[k]) x0[k] = 1;
        nstr0 = 0;
        send_frame(0, 0, ent);
        wait_done(0, 1'b0, ent, "u0_ones");
        chk("u0_ones_strobes", longint'(nstr0), longint'(NLAGS));
        chk("u0_ones_r47", longint'($signed(got0[47][63:0])), longint'(433));
        chk("u0_ones_r141", longint'($signed(got0[141][63:0])), longint'(339));
`ifdef ACF_LAG0_EN
        chk("u0_ones_r0", longint'($signed(got0[0][63:0])), longint'(480));
`endif
        foreach (x0[k]) x0[k] = -32768;
        send_frame(0, 0, ent);
        wait_done(0, 1'b0, ent, "u0_neg");
        chk("u0_neg_r47", longint'($signed(got0[47][63:0])), 64'sd464930209792);
        chk("u0_neg_upper_zero", longint'(got0[47][71:41] == '0), longint'(1));
      end
      begin : inst1
        longint ent;
        bit seen;
        for (int c = 0; c < 8; c++) begin
          drive(1, 1'b0, 1'b1, 16'($urandom));
          @(posedge clk); #1;
        end
        drive(1, 1'b0, 1'b0, 16'h0);
        chk("u1_idle_sv_busy", longint'(busy1), longint'(0));

        foreach (x1[k]) x1[k] = 0;
        x1[0] = 100;
        x1[100] = 100;
        send_frame(1, 30, ent);
        wait_done(1, 1'b0, ent, "u1_impulse");
        chk("u1_impulse_r100", longint'($signed(got1[100][63:0])), longint'(10000));
        chk("u1_impulse_r99", longint'($signed(got1[99][63:0])), longint'(0));

        foreach (x1[k]) x1[k] = int'($urandom_range(0, 65535)) - 32768;
        send_frame(1, 30, ent);
        wait_done(1, 1'b1, ent, "u1_rand_disturb");

        foreach (x1[k]) x1[k] = int'($urandom_range(0, 65535)) - 32768;
        send_frame(1, 10, ent);
        seen = 1'b0;
        for (int c = 0; c < 20000 && !seen; c++) begin
          @(negedge clk);
          if (rvalid1 === 1'b1 && rlag1 == 10'd79) seen = 1'b1;
        end
        if (!seen) begin
          total++;
          $display("FAIL u1_lag79_timeout: got no lag 79 strobe, expected one within 20000 cycles");
        end
        repeat (10) @(posedge clk);
        #1;
        rst1 = 1'b1;
        sbq1.delete();
        @(posedge clk); #1;
        rst1 = 1'b0;
        hold_lag1 = '0;
        hold_val1 = '0;
        reset_chk(1);

        foreach (x1[k]) x1[k] = int'($urandom_range(0, 65535)) - 32768;
        send_frame(1, 20, ent);
        wait_done(1, 1'b0, ent, "u1_after_reset");
      end
    join
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
